sort_pipe: RTL and testbench
============================

Name: sort_pipe

Overview:
- Pipelined, parametrised sorting network for NUM elements of WIDTH bits.
- Bitonic sorter: one compare-exchange layer per pipeline stage; accepts one full vector per cycle.
- Valid/ready handshake on both sides; per-vector ascending/descending mode travels with the data.
- Next-generation replacement for the fixed 8x8-bit combinational sorter in the datapath; sits between the sample-gather buffer and the rank/median selection logic.

Parameters:
- WIDTH, 8, bits per element (unsigned), legal 1..32.
- NUM, 8, elements per vector, power of two, legal 2..16.
- LOG2NUM, 3, log2(NUM); must match NUM. Elaboration-time check, fatal on mismatch.
- STAGES, LOG2NUM*(LOG2NUM+1)/2, pipeline depth (6 for NUM=8); derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_desc valid.
- in_ready  output  1  block accepts the vector this cycle.
- in_desc  input  1  0 = ascending, 1 = descending.
- in_data  input  NUM*WIDTH  element i at [i*WIDTH +: WIDTH].
- out_valid  output  1  out_data/out_desc valid.
- out_ready  input  1  downstream accepts this cycle.
- out_desc  output  1  mode of the vector on out_data.
- out_data  output  NUM*WIDTH  sorted vector; element 0 at LSBs.

Behaviour:
- One clock; reset is synchronous and active-high; ports named clk and rst.
- Reset: all stage valid bits, data and mode registers clear to 0. out_valid=0, out_data=0, out_desc=0.
- in_ready is 0 while rst=1.
- Reset mid-operation: every in-flight vector is discarded and no partial output appears. First accept is possible on the cycle after rst deasserts.
- Advance signal: adv = !out_valid || out_ready.
  - in_ready = adv && !rst. This is a combinational path from out_ready; it is intentional.
  - All stages shift together when adv=1. All stages hold when adv=0; data and valid bits are frozen.
- Stage 0 loads in_valid&&in_ready into its valid bit.
  - Bubbles propagate as invalid slots and are not squeezed out.
  - Accepted vector data is loaded only with valid=1. When invalid, data registers may hold stale values.
- Latency: a vector accepted at edge t appears with out_valid=1 after exactly STAGES edges, provided adv stays 1.
- Throughput: one vector per cycle while out_ready=1.
- Network: standard bitonic sort, stages ordered (k=1..LOG2NUM, j=k-1..0).
  - Comparator pair (i, i XOR 2^j) for i with bit j = 0.
  - Direction is ascending when bit k of i is 0, descending otherwise; k=LOG2NUM gives ascending for all pairs.
  - Final order is then inverted when the vector's desc bit = 1. This is implemented as a swap-sense XOR in the last layer or an output reversal, with no added stage.
- Comparison: unsigned, full WIDTH. Equal elements are not swapped; output is identical either way.
- Result: ascending gives out element 0 = minimum and element NUM-1 = maximum. Descending is the reverse.
- out_desc equals the in_desc captured with that vector.
- Handshake rules:
  - out_data and out_desc stay stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer, except on rst.
  - in_data is ignored when in_valid=0.
- Ordering: strict FIFO; vectors leave in acceptance order.

Test Plan:
- Reset, then single vector, NUM=8, WIDTH=8: in_data elements {7,3,255,0,3,128,1,64}, desc=0, out_ready=1 -> out_valid exactly 6 cycles after accept. Output {0,1,3,3,7,64,128,255}, out_desc=0, out_valid high for 1 cycle.
- Same vector with desc=1 -> {255,128,64,7,3,3,1,0}, out_desc=1.
- Back-to-back: 20 random vectors on consecutive cycles with alternating desc, out_ready=1 -> 20 outputs on 20 consecutive cycles, each matching a reference sort. No bubbles, in_ready constantly 1.
- Backpressure: stream 10 vectors while toggling out_ready randomly (about 50%) -> no loss or duplication, order preserved. out_data is stable while stalled, and in_ready equals out_ready whenever out_valid=1.
- Reset mid-stream: pulse rst while 4 vectors are in flight -> out_valid=0, out_data=0 and in_ready=0 during rst; none of the 4 vectors ever emerges. A new vector {1,1,1,1,0,0,0,0} afterwards gives {0,0,0,0,1,1,1,1}.
- Parameter sweep: NUM=2/4/16 with WIDTH=1/8/32, all-equal, already-sorted, reverse-sorted and all-max ({2^WIDTH-1} x NUM) vectors -> correct sort, and latency equal to 1/3/10 cycles for NUM=2/4/16.

Source files
------------

// File: rtl/sort_pipe_if.sv
// Handshake bundle for sort_pipe: the upstream vector input and the downstream
// sorted output. The slave modport is the sorter's view and the master modport
// is the view of the logic that drives it.
interface sort_pipe_if #(
  parameter int WIDTH = 8,
  parameter int NUM   = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_desc;
  logic [NUM*WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_desc;
  logic [NUM*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_desc, in_data, out_ready,
    input  in_ready, out_valid, out_desc, out_data
  );

  modport slave (
    input  in_valid, in_desc, in_data, out_ready,
    output in_ready, out_valid, out_desc, out_data
  );
endinterface

// File: rtl/sort_pipe.sv
// Pipelined bitonic sorter. Each pipeline stage holds the result of exactly one
// compare-exchange layer, so one vector can enter every cycle. The whole
// pipeline advances together whenever the output slot is empty or being taken.
// Descending vectors are produced by reversing the ascending result on the way
// into the last stage register, so the mode costs no extra stage.
module sort_pipe #(
  parameter int WIDTH   = 8,
  parameter int NUM     = 8,
  parameter int LOG2NUM = 3
) (
  input logic        clk,
  input logic        rst,
  sort_pipe_if.slave bus
);
  localparam int STAGES = LOG2NUM * (LOG2NUM + 1) / 2;
  localparam int VW     = NUM * WIDTH;

  if ((1 << LOG2NUM) != NUM) begin : g_bad_log2num
    $fatal(1, "sort_pipe: LOG2NUM does not match NUM");
  end

  logic              adv;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] desc_q;
  logic [VW-1:0]     data_q   [STAGES];
  logic [VW-1:0]     stage_in [STAGES];
  logic [VW-1:0]     lay_d    [STAGES];
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] din;

  // One compare-exchange layer (k = merge level, j = pair distance exponent).
  // Equal elements are left in place.
  function automatic logic [VW-1:0] cas_layer(input logic [VW-1:0] v, input int k, input int j);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             up;
    int               p;
    cas_layer = v;
    for (int i = 0; i < NUM; i++) begin
      if (((i >> j) & 1) == 0) begin
        p  = i ^ (1 << j);
        a  = v[i*WIDTH +: WIDTH];
        b  = v[p*WIDTH +: WIDTH];
        up = (((i >> k) & 1) == 0);
        if (up ? (a > b) : (a < b)) begin
          cas_layer[i*WIDTH +: WIDTH] = b;
          cas_layer[p*WIDTH +: WIDTH] = a;
        end
      end
    end
  endfunction

  function automatic logic [VW-1:0] reverse_vec(input logic [VW-1:0] v);
    for (int i = 0; i < NUM; i++)
      reverse_vec[i*WIDTH +: WIDTH] = v[(NUM-1-i)*WIDTH +: WIDTH];
  endfunction

  assign adv           = !valid_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready  = adv && !rst;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_desc  = desc_q[STAGES-1];
  assign bus.out_data  = data_q[STAGES-1];

  // Operands feeding each layer: the input port for the first, the previous register otherwise.
  always_comb begin
    stage_in[0] = bus.in_data;
    vin[0]      = bus.in_valid && bus.in_ready;
    din[0]      = bus.in_desc;
    for (int s = 1; s < STAGES; s++) begin
      stage_in[s] = data_q[s-1];
      vin[s]      = valid_q[s-1];
      din[s]      = desc_q[s-1];
    end
  end

  // Compare-exchange network, layers ordered k = 1..LOG2NUM, j = k-1..0; the
  // last layer's result is reversed for descending vectors.
  always_comb begin
    int s;
    for (int t = 0; t < STAGES; t++) lay_d[t] = stage_in[t];
    s = 0;
    for (int k = 1; k <= LOG2NUM; k++) begin
      for (int j = k - 1; j >= 0; j--) begin
        lay_d[s] = cas_layer(stage_in[s], k, j);
        s++;
      end
    end
    if (din[STAGES-1]) lay_d[STAGES-1] = reverse_vec(lay_d[STAGES-1]);
  end

  // Pipeline registers: shift together on adv; data/mode only load with a valid vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      desc_q  <= '0;
      for (int s = 0; s < STAGES; s++) data_q[s] <= '0;
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_q[s] <= vin[s];
        if (vin[s]) begin
          data_q[s] <= lay_d[s];
          desc_q[s] <= din[s];
        end
      end
    end
  end
endmodule

// File: tb/tb_sort_pipe.sv
// Directed bench for sort_pipe: the 8x8 configuration carries the handshake,
// latency and reset scenarios; NUM=2/4/16 instances cover the parameter sweep.
module tb_sort_pipe;
  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  sort_pipe_if #(.WIDTH(8),  .NUM(8))  b8  ();
  sort_pipe_if #(.WIDTH(1),  .NUM(2))  b2  ();
  sort_pipe_if #(.WIDTH(8),  .NUM(4))  b4  ();
  sort_pipe_if #(.WIDTH(32), .NUM(16)) b16 ();

  sort_pipe #(.WIDTH(8),  .NUM(8),  .LOG2NUM(3)) dut8  (.clk(clk), .rst(rst), .bus(b8.slave));
  sort_pipe #(.WIDTH(1),  .NUM(2),  .LOG2NUM(1)) dut2  (.clk(clk), .rst(rst), .bus(b2.slave));
  sort_pipe #(.WIDTH(8),  .NUM(4),  .LOG2NUM(2)) dut4  (.clk(clk), .rst(rst), .bus(b4.slave));
  sort_pipe #(.WIDTH(32), .NUM(16), .LOG2NUM(4)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: insertion sort, then reverse for descending.
  function automatic logic [511:0] ref_sort(input logic [511:0] v, input int n, input int w, input logic desc);
    logic [31:0]  e [16];
    logic [31:0]  t;
    logic [511:0] r;
    int           j;
    for (int i = 0; i < 16; i++) e[i] = '0;
    for (int i = 0; i < n; i++) begin
      t = '0;
      for (int b = 0; b < w; b++) t[b] = v[i*w+b];
      e[i] = t;
    end
    for (int i = 1; i < n; i++) begin
      t = e[i];
      j = i;
      while (j > 0 && e[j-1] > t) begin
        e[j] = e[j-1];
        j--;
      end
      e[j] = t;
    end
    r = '0;
    for (int i = 0; i < n; i++) begin
      t = desc ? e[n-1-i] : e[i];
      for (int b = 0; b < w; b++) r[i*w+b] = t[b];
    end
    return r;
  endfunction

  // Sweep patterns: 0 all-equal, 1 sorted, 2 reverse-sorted, 3 all-max, 4 scrambled.
  function automatic logic [511:0] make_pat(input int pat, input int n, input int w);
    logic [63:0]  m;
    logic [63:0]  x;
    logic [511:0] r;
    m = (64'd1 << w) - 64'd1;
    r = '0;
    for (int i = 0; i < n; i++) begin
      case (pat)
        0:       x = m & 64'h35;
        1:       x = (64'(i) * m) / 64'(n - 1);
        2:       x = (64'(n - 1 - i) * m) / 64'(n - 1);
        3:       x = m;
        default: x = (64'((i * 5 + 3) % n) * m) / 64'(n - 1);
      endcase
      for (int b = 0; b < w; b++) r[i*w+b] = x[b];
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    b8.in_valid  = 1'b1;
    b8.in_desc   = 1'b1;
    b8.in_data   = 64'h1122334455667788;
    b8.out_ready = 1'b0;
    repeat (3) tick();
    nvec++; if (b8.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", b8.out_valid); end
    nvec++; if (b8.out_data !== 64'h0) begin nerr++; $display("FAIL reset_out_data: got %h want 0", b8.out_data); end
    nvec++; if (b8.out_desc !== 1'b0) begin nerr++; $display("FAIL reset_out_desc: got %b want 0", b8.out_desc); end
    nvec++; if (b8.in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready: got %b want 0", b8.in_ready); end
    nvec++; if (b2.out_valid !== 1'b0 || b4.out_valid !== 1'b0 || b16.out_valid !== 1'b0) begin
      nerr++; $display("FAIL reset_sweep_valid: got %b%b%b want 000", b2.out_valid, b4.out_valid, b16.out_valid);
    end
    rst = 1'b0;
    b8.in_valid = 1'b0;
    #1;
    nvec++; if (b8.in_ready !== 1'b1) begin nerr++; $display("FAIL post_reset_in_ready: got %b want 1", b8.in_ready); end
    b8.out_ready = 1'b1;
  endtask

  task automatic test_single(input logic desc, input logic [63:0] v, input logic [63:0] exp);
    int lat;
    b8.out_ready = 1'b1;
    b8.in_valid  = 1'b1;
    b8.in_desc   = desc;
    b8.in_data   = v;
    #1;
    nvec++; if (b8.in_ready !== 1'b1) begin nerr++; $display("FAIL single_in_ready: got %b want 1", b8.in_ready); end
    tick();
    b8.in_valid = 1'b0;
    b8.in_data  = 64'hdeadbeefdeadbeef;
    lat = 1;
    while (!b8.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    nvec++; if (lat !== 6) begin nerr++; $display("FAIL single_latency: got %0d want 6", lat); end
    nvec++; if (b8.out_data !== exp) begin nerr++; $display("FAIL single_data: got %h want %h", b8.out_data, exp); end
    nvec++; if (b8.out_desc !== desc) begin nerr++; $display("FAIL single_desc: got %b want %b", b8.out_desc, desc); end
    tick();
    nvec++; if (b8.out_valid !== 1'b0) begin nerr++; $display("FAIL single_one_cycle: got %b want 0", b8.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0]  eq [$];
    logic         edq [$];
    logic [63:0]  v;
    logic [511:0] r;
    logic         d;
    int           got = 0;
    int           first = -1;
    int           last = -1;
    b8.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c < 20) begin
        v = {$urandom, $urandom};
        d = c[0];
        b8.in_valid = 1'b1;
        b8.in_desc  = d;
        b8.in_data  = v;
        r = ref_sort({448'd0, v}, 8, 8, d);
        eq.push_back(r[63:0]);
        edq.push_back(d);
        #1;
        nvec++; if (b8.in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_in_ready: cycle %0d got %b want 1", c, b8.in_ready); end
      end else begin
        b8.in_valid = 1'b0;
      end
      tick();
      if (b8.out_valid) begin
        nvec++;
        if (eq.size() == 0) begin
          nerr++; $display("FAIL b2b_extra: got unexpected vector %h want none", b8.out_data);
        end else begin
          if (b8.out_data !== eq[0] || b8.out_desc !== edq[0]) begin
            nerr++; $display("FAIL b2b_data: got %h/%b want %h/%b", b8.out_data, b8.out_desc, eq[0], edq[0]);
          end
          void'(eq.pop_front());
          void'(edq.pop_front());
        end
        got++;
        if (first < 0) first = c;
        last = c;
      end
    end
    nvec++; if (got !== 20) begin nerr++; $display("FAIL b2b_count: got %0d want 20", got); end
    nvec++; if (last - first !== 19) begin nerr++; $display("FAIL b2b_contiguous: got span %0d want 19", last - first); end
  endtask

  task automatic test_backpressure();
    logic [63:0]  eq [$];
    logic         edq [$];
    logic [63:0]  v;
    logic [63:0]  hold_d;
    logic         hold_m;
    logic [511:0] r;
    logic         stalled;
    int           sent = 0;
    int           got = 0;
    int           cyc = 0;
    stalled = 1'b0;
    hold_d  = '0;
    hold_m  = 1'b0;
    while (got < 10 && cyc < 300) begin
      b8.out_ready = 1'($urandom_range(0, 1));
      b8.in_valid  = (sent < 10);
      v            = {$urandom, $urandom};
      b8.in_data   = v;
      b8.in_desc   = sent[0];
      #1;
      if (b8.out_valid) begin
        nvec++; if (b8.in_ready !== b8.out_ready) begin nerr++; $display("FAIL bp_in_ready: got %b want %b", b8.in_ready, b8.out_ready); end
      end
      if (b8.out_valid && b8.out_ready) begin
        nvec++;
        if (eq.size() == 0) begin
          nerr++; $display("FAIL bp_extra: got unexpected vector %h want none", b8.out_data);
        end else begin
          if (b8.out_data !== eq[0] || b8.out_desc !== edq[0]) begin
            nerr++; $display("FAIL bp_data: got %h/%b want %h/%b", b8.out_data, b8.out_desc, eq[0], edq[0]);
          end
          void'(eq.pop_front());
          void'(edq.pop_front());
        end
        got++;
      end
      stalled = b8.out_valid && !b8.out_ready;
      hold_d  = b8.out_data;
      hold_m  = b8.out_desc;
      if (b8.in_valid && b8.in_ready) begin
        r = ref_sort({448'd0, v}, 8, 8, b8.in_desc);
        eq.push_back(r[63:0]);
        edq.push_back(b8.in_desc);
        sent++;
      end
      tick();
      cyc++;
      if (stalled) begin
        nvec++;
        if (b8.out_valid !== 1'b1 || b8.out_data !== hold_d || b8.out_desc !== hold_m) begin
          nerr++; $display("FAIL bp_stable: got %b/%h/%b want 1/%h/%b", b8.out_valid, b8.out_data, b8.out_desc, hold_d, hold_m);
        end
      end
    end
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b1;
    nvec++; if (got !== 10 || eq.size() !== 0) begin nerr++; $display("FAIL bp_count: got %0d left %0d want 10 left 0", got, eq.size()); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    b8.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      b8.in_valid = 1'b1;
      b8.in_desc  = c[0];
      b8.in_data  = 64'h0102030405060708 + 64'(c);
      tick();
    end
    b8.in_valid = 1'b1;
    rst = 1'b1;
    #1;
    nvec++; if (b8.in_ready !== 1'b0) begin nerr++; $display("FAIL mid_rst_in_ready: got %b want 0", b8.in_ready); end
    tick();
    nvec++; if (b8.out_valid !== 1'b0) begin nerr++; $display("FAIL mid_rst_out_valid: got %b want 0", b8.out_valid); end
    nvec++; if (b8.out_data !== 64'h0) begin nerr++; $display("FAIL mid_rst_out_data: got %h want 0", b8.out_data); end
    nvec++; if (b8.in_ready !== 1'b0) begin nerr++; $display("FAIL mid_rst_in_ready_held: got %b want 0", b8.in_ready); end
    tick();
    rst = 1'b0;
    b8.in_valid = 1'b0;
    #1;
    nvec++; if (b8.in_ready !== 1'b1) begin nerr++; $display("FAIL mid_rst_release_ready: got %b want 1", b8.in_ready); end
    repeat (10) begin
      tick();
      if (b8.out_valid) seen++;
    end
    nvec++; if (seen !== 0) begin nerr++; $display("FAIL mid_rst_ghost: got %0d outputs want 0", seen); end
    test_single(1'b0, 64'h0000000001010101, 64'h0101010100000000);
  endtask

  task automatic test_sweep();
    logic [511:0] v2, v4, v16, o2, o4, o16, x;
    logic         d, m2, m4, m16;
    int           l2, l4, l16;
    for (int pat = 0; pat < 5; pat++) begin
      d   = pat[0];
      v2  = make_pat(pat, 2, 1);
      v4  = make_pat(pat, 4, 8);
      v16 = make_pat(pat, 16, 32);
      b2.in_valid  = 1'b1; b2.in_desc  = d; b2.in_data  = v2[1:0];
      b4.in_valid  = 1'b1; b4.in_desc  = d; b4.in_data  = v4[31:0];
      b16.in_valid = 1'b1; b16.in_desc = d; b16.in_data = v16;
      tick();
      b2.in_valid = 1'b0; b4.in_valid = 1'b0; b16.in_valid = 1'b0;
      l2 = 0; l4 = 0; l16 = 0;
      o2 = '0; o4 = '0; o16 = '0;
      m2 = 1'b0; m4 = 1'b0; m16 = 1'b0;
      for (int c = 1; c <= 16; c++) begin
        if (l2 == 0 && b2.out_valid) begin l2 = c; o2[1:0] = b2.out_data; m2 = b2.out_desc; end
        if (l4 == 0 && b4.out_valid) begin l4 = c; o4[31:0] = b4.out_data; m4 = b4.out_desc; end
        if (l16 == 0 && b16.out_valid) begin l16 = c; o16 = b16.out_data; m16 = b16.out_desc; end
        tick();
      end
      nvec++; if (l2 !== 1) begin nerr++; $display("FAIL sweep2_latency: pat %0d got %0d want 1", pat, l2); end
      nvec++; if (l4 !== 3) begin nerr++; $display("FAIL sweep4_latency: pat %0d got %0d want 3", pat, l4); end
      nvec++; if (l16 !== 10) begin nerr++; $display("FAIL sweep16_latency: pat %0d got %0d want 10", pat, l16); end
      x = ref_sort(v2, 2, 1, d);
      nvec++; if (o2 !== x) begin nerr++; $display("FAIL sweep2_data: pat %0d got %h want %h", pat, o2[1:0], x[1:0]); end
      x = ref_sort(v4, 4, 8, d);
      nvec++; if (o4 !== x) begin nerr++; $display("FAIL sweep4_data: pat %0d got %h want %h", pat, o4[31:0], x[31:0]); end
      x = ref_sort(v16, 16, 32, d);
      nvec++; if (o16 !== x) begin nerr++; $display("FAIL sweep16_data: pat %0d got %h want %h", pat, o16, x); end
      nvec++; if (m2 !== d || m4 !== d || m16 !== d) begin
        nerr++; $display("FAIL sweep_desc: pat %0d got %b%b%b want %b", pat, m2, m4, m16, d);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    b8.in_valid  = 1'b0; b8.in_desc  = 1'b0; b8.in_data  = '0; b8.out_ready  = 1'b1;
    b2.in_valid  = 1'b0; b2.in_desc  = 1'b0; b2.in_data  = '0; b2.out_ready  = 1'b1;
    b4.in_valid  = 1'b0; b4.in_desc  = 1'b0; b4.in_data  = '0; b4.out_ready  = 1'b1;
    b16.in_valid = 1'b0; b16.in_desc = 1'b0; b16.in_data = '0; b16.out_ready = 1'b1;
    test_reset();
    test_single(1'b0, 64'h40018003_00ff0307, 64'hff804007_03030100);
    test_single(1'b1, 64'h40018003_00ff0307, 64'h00010303_074080ff);
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
